cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates one shared L2 line port between an instruction-side reader and a data-side reader/writer.
// Latency: request seen in IDLE is granted at the next edge; resp is combinational with l2_resp, then one IDLE cycle.
// Backpressure: requesters hold their request until resp; the L2 port is held stable until l2_resp.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_read/i_addr -> i_rdata/i_resp              instruction-side line read
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp  data-side line read or writeback
//   l2_read/l2_write/l2_addr/l2_wdata <- l2_rdata/l2_resp  shared L2 port
module cache_arbiter #(
    parameter int s_offset = 5,
    parameter int s_addr   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_read,
    input  logic [s_addr-1:0]               i_addr,
    output logic [8*(2**s_offset)-1:0]      i_rdata,
    output logic                            i_resp,
    input  logic                            d_read,
    input  logic                            d_write,
    input  logic [s_addr-1:0]               d_addr,
    input  logic [8*(2**s_offset)-1:0]      d_wdata,
    output logic [8*(2**s_offset)-1:0]      d_rdata,
    output logic                            d_resp,
    output logic                            l2_read,
    output logic                            l2_write,
    output logic [s_addr-1:0]               l2_addr,
    output logic [8*(2**s_offset)-1:0]      l2_wdata,
    input  logic [8*(2**s_offset)-1:0]      l2_rdata,
    input  logic                            l2_resp
);

    localparam int LINE = 8 * (2 ** s_offset);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_write;
    logic [s_addr-1:0]   r_addr;
    logic [LINE-1:0]     r_wdata;

    logic                w_i_pend;
    logic                w_d_pend;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_live;
    logic                w_serving;
    logic [s_addr-1:0]   w_i_addr_aln;
    logic [s_addr-1:0]   w_d_addr_aln;

    assign w_i_pend     = i_read;
    assign w_d_pend     = d_read | d_write;
    assign w_i_addr_aln = {i_addr[s_addr-1:s_offset], {s_offset{1'b0}}};
    assign w_d_addr_aln = {d_addr[s_addr-1:s_offset], {s_offset{1'b0}}};

    // Grants are only decided in IDLE, so requester inputs are ignored
    // for the whole life of a transaction.
    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_pend && w_d_pend) begin
                    // Tie: give it to the side that did not win last time.
                    if (r_last_grant == GRANT_D) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_i_pend) begin
                    w_grant_i = 1'b1;
                end else if (w_d_pend) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) begin
                    w_next = SERVE_I;
                end else if (w_grant_d) begin
                    w_next = SERVE_D;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    w_next = IDLE;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_last_grant <= GRANT_I;
                r_write      <= 1'b0;
                r_addr       <= w_i_addr_aln;
                r_wdata      <= '0;
            end else if (w_grant_d) begin
                // A writeback wins over a read when both are raised together.
                r_last_grant <= GRANT_D;
                r_write      <= d_write;
                r_addr       <= w_d_addr_aln;
                r_wdata      <= d_write ? d_wdata : '0;
            end
        end
    end

    // Outputs are gated by rst so they read zero during the reset cycle
    // even if the state register still holds a serving state.
    assign w_live    = ~rst;
    assign w_serving = w_live && ((r_state == SERVE_I) || (r_state == SERVE_D));

    assign l2_read  = w_live && ((r_state == SERVE_I) || ((r_state == SERVE_D) && !r_write));
    assign l2_write = w_live && (r_state == SERVE_D) && r_write;
    assign l2_addr  = w_serving ? r_addr : '0;
    assign l2_wdata = w_serving ? r_wdata : '0;

    assign i_resp  = w_live && (r_state == SERVE_I) && l2_resp;
    assign d_resp  = w_live && (r_state == SERVE_D) && l2_resp;
    assign i_rdata = i_resp ? l2_rdata : '0;
    assign d_rdata = d_resp ? l2_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed requests, an L2 responder model and a response monitor.
// Latency: checks round-trip cycle counts per transaction.
// Backpressure: requesters hold requests until resp, L2 model holds l2_resp for one cycle.
module tb_cache_arbiter;

    localparam int LINE = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_read = 1'b0;
    logic [31:0]       i_addr = '0;
    logic [LINE-1:0]   i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [LINE-1:0]   d_wdata = '0;
    logic [LINE-1:0]   d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [31:0]       l2_addr;
    logic [LINE-1:0]   l2_wdata;
    logic [LINE-1:0]   l2_rdata = '0;
    logic              l2_resp = 1'b0;

    cache_arbiter #(.s_offset(5), .s_addr(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     addr;
        logic            wr;
        logic [LINE-1:0] wdata;
        logic [LINE-1:0] rdata;
        int              lat;
    } l2_exp_t;

    typedef struct {
        logic            side;   // 0 = I, 1 = D
        logic [LINE-1:0] rdata;
    } resp_exp_t;

    l2_exp_t   l2_q[$];
    resp_exp_t resp_q[$];
    logic      l2_auto = 1'b1;
    int        checks = 0;
    int        passes = 0;

    task automatic chk(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_l2(input logic [31:0] a, input logic wr, input logic [LINE-1:0] w,
                           input logic [LINE-1:0] r, input int lat);
        l2_exp_t e;
        e.addr = a; e.wr = wr; e.wdata = w; e.rdata = r; e.lat = lat;
        l2_q.push_back(e);
    endtask

    task automatic push_resp(input logic side, input logic [LINE-1:0] r);
        resp_exp_t e;
        e.side = side; e.rdata = r;
        resp_q.push_back(e);
    endtask

    // L2 responder: checks each new request against the expected queue,
    // holds it under observation until it answers after 'lat' cycles.
    initial begin
        l2_exp_t cur;
        logic    have;
        forever begin
            @(negedge clk);
            if (l2_auto && (l2_read || l2_write)) begin
                have = (l2_q.size() != 0);
                chk("l2_req_expected", have, 1'b1);
                if (have) begin
                    cur = l2_q.pop_front();
                end else begin
                    cur.addr = l2_addr; cur.wr = l2_write; cur.wdata = l2_wdata;
                    cur.rdata = '0; cur.lat = 1;
                end
                chk("l2_addr", l2_addr, cur.addr);
                chk("l2_write", l2_write, cur.wr);
                chk("l2_read", l2_read, !cur.wr);
                chk("l2_wdata", l2_wdata, cur.wdata);
                for (int k = 1; k <= cur.lat; k++) begin
                    @(posedge clk); #1;
                    if (k == cur.lat) begin
                        l2_resp = 1'b1;
                        l2_rdata = cur.rdata;
                    end
                    @(negedge clk);
                    chk("l2_hold_addr", l2_addr, cur.addr);
                    chk("l2_hold_op", {l2_read, l2_write}, {!cur.wr, cur.wr});
                    chk("l2_hold_wdata", l2_wdata, cur.wdata);
                end
                @(posedge clk); #1;
                l2_resp = 1'b0;
                l2_rdata = '0;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_exp_t e;
        logic      have;
        chk("resp_exclusive", i_resp & d_resp, 1'b0);
        if (!i_resp) chk("i_rdata_zero", i_rdata, '0);
        if (!d_resp) chk("d_rdata_zero", d_rdata, '0);
        if (i_resp || d_resp) begin
            have = (resp_q.size() != 0);
            chk("resp_expected", have, 1'b1);
            if (have) begin
                e = resp_q.pop_front();
                chk("resp_side", d_resp, e.side);
                chk("resp_rdata", d_resp ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    // Requester tasks: entered just after a rising edge; n counts cycles to resp.
    task automatic i_req(input logic [31:0] a, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        i_addr = a;
        i_read = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (i_resp) begin got = 1'b1; break; end
            n++;
        end
        chk("i_req_done", got, 1'b1);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic d_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LINE-1:0] w, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        d_addr = a;
        d_wdata = w;
        d_read = rd;
        d_write = wr;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (d_resp) begin got = 1'b1; break; end
            n++;
        end
        chk("d_req_done", got, 1'b1);
        @(posedge clk); #1;
        d_read = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {l2_read, l2_write, i_resp, d_resp, l2_addr}, '0);
        chk(name, l2_wdata | i_rdata | d_rdata, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("zero_in_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("zero_after_rst");
    endtask

    initial begin
        int n1, n2;
        logic [LINE-1:0] data_a, data_b, data_c, data_w;
        data_a = {8{32'hA000_0001}};
        data_b = {8{32'hB000_0002}};
        data_c = {8{32'hC000_0003}};
        data_w = {8{32'h5EED_0004}};

        do_reset();
        @(posedge clk); #1;

        // I-only read, L2 answers 3 cycles after l2_read.
        push_l2(32'h0000_1220, 1'b0, '0, data_a, 3);
        push_resp(1'b0, data_a);
        i_req(32'h0000_1234, n1);
        chk("i_only_latency", n1, 4);

        // Simultaneous first requests after reset: I then D.
        do_reset();
        @(posedge clk); #1;
        push_l2(32'h0000_2000, 1'b0, '0, data_b, 1);
        push_l2(32'h0000_3000, 1'b0, '0, data_c, 1);
        push_resp(1'b0, data_b);
        push_resp(1'b1, data_c);
        fork
            i_req(32'h0000_2004, n1);
            d_req(1'b1, 1'b0, 32'h0000_3010, '0, n2);
        join
        chk("tie_i_latency", n1, 2);
        chk("tie_d_latency", n2, 5);

        // Sustained contention: I,D,I,D,I,D (last grant was D).
        push_l2(32'h0000_0100, 1'b0, '0, {8{32'h1111_0001}}, 1);
        push_l2(32'h0000_0200, 1'b0, '0, {8{32'h2222_0001}}, 2);
        push_l2(32'h0000_0140, 1'b0, '0, {8{32'h1111_0002}}, 1);
        push_l2(32'h0000_0240, 1'b0, '0, {8{32'h2222_0002}}, 1);
        push_l2(32'h0000_0180, 1'b0, '0, {8{32'h1111_0003}}, 2);
        push_l2(32'h0000_0280, 1'b0, '0, {8{32'h2222_0003}}, 1);
        push_resp(1'b0, {8{32'h1111_0001}});
        push_resp(1'b1, {8{32'h2222_0001}});
        push_resp(1'b0, {8{32'h1111_0002}});
        push_resp(1'b1, {8{32'h2222_0002}});
        push_resp(1'b0, {8{32'h1111_0003}});
        push_resp(1'b1, {8{32'h2222_0003}});
        fork
            begin
                i_req(32'h0000_0100, n1);
                i_req(32'h0000_015C, n1);
                i_req(32'h0000_0181, n1);
            end
            begin
                d_req(1'b1, 1'b0, 32'h0000_0205, '0, n2);
                d_req(1'b1, 1'b0, 32'h0000_024F, '0, n2);
                d_req(1'b1, 1'b0, 32'h0000_029F, '0, n2);
            end
        join

        // Writeback with d_read also high: write wins.
        push_l2(32'h8000_0020, 1'b1, data_w, '0, 2);
        push_resp(1'b1, '0);
        d_req(1'b1, 1'b1, 32'h8000_003F, data_w, n2);
        chk("wb_latency", n2, 3);

        // Address change after grant must not reach L2.
        push_l2(32'h0000_4440, 1'b0, '0, data_c, 4);
        push_resp(1'b1, data_c);
        fork
            d_req(1'b1, 1'b0, 32'h0000_4444, '0, n2);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                d_addr = 32'hFFFF_FFE0;
            end
        join

        // Reset two cycles into SERVE_I, then a stray l2_resp in IDLE.
        l2_auto = 1'b0;
        i_addr = 32'h0000_5000;
        i_read = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_serve_l2_read", l2_read, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst_zero");
        @(posedge clk); #1;
        rst = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_rst_after_zero");
        @(posedge clk); #1;
        l2_resp = 1'b1;
        l2_rdata = data_a;
        @(negedge clk);
        chk("idle_resp_ignored", {i_resp, d_resp, l2_read, l2_write}, 4'b0000);
        @(posedge clk); #1;
        l2_resp = 1'b0;
        l2_rdata = '0;
        @(negedge clk);
        chk("idle_stays_idle", {l2_read, l2_write}, 2'b00);
        @(posedge clk); #1;
        l2_auto = 1'b1;

        // After reset the next tie goes to I again.
        push_l2(32'h0000_6000, 1'b0, '0, data_a, 1);
        push_l2(32'h0000_7000, 1'b0, '0, data_b, 1);
        push_resp(1'b0, data_a);
        push_resp(1'b1, data_b);
        fork
            i_req(32'h0000_6008, n1);
            d_req(1'b1, 1'b0, 32'h0000_7008, '0, n2);
        join
        chk("post_rst_tie_i_first", n1 < n2, 1'b1);

        repeat (3) @(posedge clk);
        chk("l2_queue_drained", l2_q.size(), 0);
        chk("resp_queue_drained", resp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
